multi_rate_tick_gen: RTL
========================

# multi_rate_tick_gen

Parametrised, runtime-programmable successor to the fixed clock-divider topEntity: generates NUM_CH independent one-cycle enable pulses (ticks) from the 100 MHz system clock, one per periodic RTLola stream. Each channel has a programmable period and phase. Reconfiguration is glitch-free: it is applied at the channel's next tick. All channels can be re-aligned with one sync pulse. Sits between the clock/reset root and the generated stream evaluators, replacing the hard-wired clk1..clk5 dividers.

## Interface
Parameters:
- NUM_CH, 5, number of tick channels (1..32)
- CNT_W, 24, period/phase/counter width in bits

Ports:
- clk  in  1  system clock, 100 MHz
- rst  in  1  asynchronous, active-low reset
- en  in  1  global count enable; low freezes all counters
- sync_clr  in  1  restart all channels at their phases
- cfg_we  in  1  configuration write strobe
- cfg_ch  in  $clog2(NUM_CH) (min 1)  target channel index
- cfg_period  in  CNT_W  new period in enabled cycles; 0 = channel disabled
- cfg_phase  in  CNT_W  new start offset
- tick  out  NUM_CH  registered one-cycle pulse per channel
- all_tick  out  1  registered; every enabled channel ticks this cycle
- cfg_pending  out  NUM_CH  shadow config waiting for the channel's next wrap

## Operation
- Per channel state: active period P and phase F, counter cnt, shadow period/phase, pending flag.
- Reset (async assert, sync-release safe): P=0, F=0, cnt=0, shadow=0, tick=0, all_tick=0, cfg_pending=0.
- P=0: channel idle; cnt held at 0; tick=0.
- P≥1, en=1, no sync_clr:
  - cnt==P-1: cnt←0, tick←1.
  - otherwise: cnt←cnt+1, tick←0.
- en=0: cnt, pending and shadows hold; tick←0 and all_tick←0. Config writes are still accepted.
- Phase: a loaded F with F≥P is treated as 0. The first tick comes P-F enabled edges after the load.
- Config write (cfg_we=1, cfg_ch<NUM_CH). Writes with cfg_ch≥NUM_CH are ignored.
  - Channel idle (P=0): applied at the same edge. P←cfg_period, F←cfg_phase, cnt←phase, tick←0, pending stays 0.
  - Channel running: stored in shadow, pending←1. On the channel's next wrap edge, tick←1 for the completing old period, P/F←shadow, cnt←shadow phase, pending←0.
  - Write on the same edge as that channel's wrap: new values go directly to active and are loaded as above. Pending stays 0.
  - Repeated writes before the wrap: the last write wins.
  - Shadow period 0 disables the channel after its final tick.
- sync_clr=1 (highest priority, regardless of en):
  - Pending shadows are applied first.
  - Every channel then loads cnt←F; tick←0, all_tick←0, pending←0.
  - A cfg_we in the same cycle is applied as an immediate write.
- all_tick←1 when at least one channel has P≠0 and tick would be 1 on every channel with P≠0 this edge.

## Timing
- All outputs are registered. There is no combinational path from inputs to outputs.
- Latency: period P, phase 0, en high from the first edge after reset release → first tick high after edge P, then every P enabled edges.
- P=1 → tick high on every enabled cycle.
- Counters never exceed P-1. With maximum period 2^CNT_W-1 the counter does not overflow.
- Asynchronous reset mid-operation clears all outputs immediately. Nothing is retained.

## Structure
- Package tick_gen_pkg:
  - cnt_t (logic [CNT_W-1:0])
  - chan_cfg_t struct {period, phase}
  - CH_IDX_W constant
- Sub-module tick_channel:
  - one instance per channel via generate
  - contains counter, active/shadow config and pending flag
- Top level:
  - decodes cfg_ch into per-channel write strobes
  - distributes sync_clr
  - reduces per-channel wrap/active signals into all_tick

## Test plan
- Reset, write ch0 P=4 F=0, en=1 → tick[0] high on edges 4, 8, 12 after the write. Other channels stay 0. cfg_pending=0.
- ch1 running P=3, write P=5 mid-period → cfg_pending[1]=1 until the next tick. That tick appears on schedule, then spacing becomes 5.
- ch0 P=2 F=0, ch1 P=4 F=0, sync_clr → all_tick high every 4th edge. Write ch1 P=0 → all_tick follows ch0, every 2nd edge.
- P=6 F=4 load → first tick 2 edges later. Load with F=7 → treated as F=0, first tick after 6 edges.
- en low for 10 cycles mid-period → ticks stop, counters frozen. Ticks resume with the remaining count, no extra or lost pulse.
- Pending write then sync_clr in the same cycle as a cfg_we to another channel → both configs active immediately. All channels restart at their phases. pending=0.
- Assert rst mid-count → all outputs 0 asynchronously. After release no ticks until reprogrammed.

Source files
------------

// File: rtl/tick_gen_pkg.sv
// Shared types and sizing helpers for the multi-rate tick generator.
// Default widths match the original five-stream, 24-bit divider set.
package tick_gen_pkg;

    localparam int unsigned DEF_NUM_CH = 5;
    localparam int unsigned DEF_CNT_W  = 24;

    typedef logic [DEF_CNT_W-1:0] cnt_t;

    typedef struct packed {
        cnt_t period;
        cnt_t phase;
    } chan_cfg_t;

    // Channel index width, never below one bit so a single channel still has a select.
    function automatic int unsigned idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int unsigned CH_IDX_W = idx_w(DEF_NUM_CH);

endpackage

// File: rtl/tick_channel.sv
// One programmable tick channel: counter, active/shadow period+phase, pending flag.
// Shadow config is committed on the channel's own wrap so running periods never glitch.
module tick_channel
    import tick_gen_pkg::*;
#(
    parameter int unsigned CNT_W = 24
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             sync_clr,
    input  logic             we,
    input  logic [CNT_W-1:0] wr_period,
    input  logic [CNT_W-1:0] wr_phase,
    output logic             tick,
    output logic             pending,
    output logic             active,
    output logic             wrap
);

    logic [CNT_W-1:0] per_q, per_d, pha_q, pha_d, cnt_q, cnt_d;
    logic [CNT_W-1:0] sh_per_q, sh_per_d, sh_pha_q, sh_pha_d;
    logic [CNT_W-1:0] nper, npha;
    logic             pend_q, pend_d, tick_q, tick_d;

    // A phase at or beyond the period would never match the wrap compare; clamp it to 0.
    function automatic logic [CNT_W-1:0] eff_phase(input logic [CNT_W-1:0] p,
                                                   input logic [CNT_W-1:0] f);
        return (f >= p) ? '0 : f;
    endfunction

    assign active = (per_q != '0);
    assign wrap   = en && !sync_clr && active && (cnt_q == per_q - CNT_W'(1));

    always_comb begin
        per_d    = per_q;
        pha_d    = pha_q;
        cnt_d    = cnt_q;
        sh_per_d = sh_per_q;
        sh_pha_d = sh_pha_q;
        pend_d   = pend_q;
        tick_d   = 1'b0;
        nper     = pend_q ? sh_per_q : per_q;
        npha     = pend_q ? sh_pha_q : pha_q;

        if (sync_clr) begin
            if (we) begin
                nper = wr_period;
                npha = wr_phase;
            end
            per_d  = nper;
            pha_d  = npha;
            cnt_d  = eff_phase(nper, npha);
            pend_d = 1'b0;
        end else if (we && (!active || wrap)) begin
            per_d  = wr_period;
            pha_d  = wr_phase;
            cnt_d  = eff_phase(wr_period, wr_phase);
            pend_d = 1'b0;
            tick_d = wrap;
        end else begin
            if (we) begin
                sh_per_d = wr_period;
                sh_pha_d = wr_phase;
                pend_d   = 1'b1;
            end
            if (wrap) begin
                tick_d = 1'b1;
                if (pend_q) begin
                    per_d  = sh_per_q;
                    pha_d  = sh_pha_q;
                    cnt_d  = eff_phase(sh_per_q, sh_pha_q);
                    pend_d = 1'b0;
                end else begin
                    cnt_d = '0;
                end
            end else if (!active) begin
                cnt_d = '0;
            end else if (en) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            per_q    <= '0;
            pha_q    <= '0;
            cnt_q    <= '0;
            sh_per_q <= '0;
            sh_pha_q <= '0;
            pend_q   <= 1'b0;
            tick_q   <= 1'b0;
        end else begin
            per_q    <= per_d;
            pha_q    <= pha_d;
            cnt_q    <= cnt_d;
            sh_per_q <= sh_per_d;
            sh_pha_q <= sh_pha_d;
            pend_q   <= pend_d;
            tick_q   <= tick_d;
        end
    end

    assign tick    = tick_q;
    assign pending = pend_q;

endmodule

// File: rtl/multi_rate_tick_gen.sv
// Runtime-programmable multi-rate enable generator, one tick channel per periodic stream.
// Decodes config writes, fans out sync_clr and registers the all-channels-coincide flag.
module multi_rate_tick_gen
    import tick_gen_pkg::*;
#(
    parameter int unsigned NUM_CH = 5,
    parameter int unsigned CNT_W  = 24
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic                     sync_clr,
    input  logic                     cfg_we,
    input  logic [idx_w(NUM_CH)-1:0] cfg_ch,
    input  logic [CNT_W-1:0]         cfg_period,
    input  logic [CNT_W-1:0]         cfg_phase,
    output logic [NUM_CH-1:0]        tick,
    output logic                     all_tick,
    output logic [NUM_CH-1:0]        cfg_pending
);

    localparam int unsigned IdxW = idx_w(NUM_CH);

    logic [NUM_CH-1:0] we_vec, active_vec, wrap_vec;
    logic              all_tick_q, all_tick_d;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        // Indices at or above NUM_CH match no channel, so such writes fall away.
        assign we_vec[i] = cfg_we && (cfg_ch == IdxW'(i));

        tick_channel #(
            .CNT_W (CNT_W)
        ) u_ch (
            .clk       (clk),
            .rst       (rst),
            .en        (en),
            .sync_clr  (sync_clr),
            .we        (we_vec[i]),
            .wr_period (cfg_period),
            .wr_phase  (cfg_phase),
            .tick      (tick[i]),
            .pending   (cfg_pending[i]),
            .active    (active_vec[i]),
            .wrap      (wrap_vec[i])
        );
    end

    always_comb begin
        all_tick_d = (|active_vec) && ((wrap_vec | ~active_vec) == '1);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            all_tick_q <= 1'b0;
        end else begin
            all_tick_q <= all_tick_d;
        end
    end

    assign all_tick = all_tick_q;

endmodule
